// File: rtl/axi_slv_mem.sv
// AXI slave memory: independent write/read FSMs, INCR full-width bursts, one outstanding per side.
// Define AXI_SLV_MEM_ERR_EN to return SLVERR for out-of-range beats instead of wrapping.
module axi_slv_mem #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned MEM_DEPTH      = 256
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [AXI_ID_WIDTH-1:0]     aw_id,
  input  logic [AXI_ADDR_WIDTH-1:0]   aw_addr,
  input  logic [7:0]                  aw_len,
  input  logic                        aw_valid,
  output logic                        aw_ready,
  input  logic [AXI_DATA_WIDTH-1:0]   w_data,
  input  logic [AXI_DATA_WIDTH/8-1:0] w_strb,
  input  logic                        w_last,
  input  logic                        w_valid,
  output logic                        w_ready,
  output logic [AXI_ID_WIDTH-1:0]     b_id,
  output logic [1:0]                  b_resp,
  output logic                        b_valid,
  input  logic                        b_ready,
  input  logic [AXI_ID_WIDTH-1:0]     ar_id,
  input  logic [AXI_ADDR_WIDTH-1:0]   ar_addr,
  input  logic [7:0]                  ar_len,
  input  logic                        ar_valid,
  output logic                        ar_ready,
  output logic [AXI_ID_WIDTH-1:0]     r_id,
  output logic [AXI_DATA_WIDTH-1:0]   r_data,
  output logic [1:0]                  r_resp,
  output logic                        r_last,
  output logic                        r_valid,
  input  logic                        r_ready
);

  localparam int unsigned StrbW     = AXI_DATA_WIDTH / 8;
  localparam int unsigned ByteShift = $clog2(StrbW);
  localparam int unsigned IdxW      = AXI_ADDR_WIDTH - ByteShift;
  localparam int unsigned MemAw     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

`ifdef AXI_SLV_MEM_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic [0:0] {RIdle, RData} r_state_e;

  function automatic logic [MemAw-1:0] mem_addr(input logic [IdxW-1:0] idx);
    logic [IdxW-1:0] wrapped;
    wrapped = idx % IdxW'(MEM_DEPTH);
    return wrapped[MemAw-1:0];
  endfunction

  function automatic logic in_range(input logic [IdxW-1:0] idx);
    return idx < IdxW'(MEM_DEPTH);
  endfunction

  logic [AXI_DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  w_state_e                w_state_q, w_state_d;
  logic [IdxW-1:0]         w_idx_q;
  logic [7:0]              w_len_q, w_cnt_q;
  logic                    w_err_q;
  logic [AXI_ID_WIDTH-1:0] b_id_q;
  logic                    aw_hs, w_hs, w_ok;

  r_state_e                  r_state_q, r_state_d;
  logic [IdxW-1:0]           r_idx_q, rd_idx;
  logic [7:0]                r_len_q, r_cnt_q;
  logic [AXI_ID_WIDTH-1:0]   r_id_q;
  logic [AXI_DATA_WIDTH-1:0] r_data_q, rd_word;
  logic [1:0]                r_resp_q;
  logic                      r_last_q, ar_hs, r_hs, rd_ok;

  // Byte-offset bits and w_last carry no information for full-width bursts.
  logic unused_inputs;
  assign unused_inputs = ^{w_last, aw_addr[ByteShift-1:0], ar_addr[ByteShift-1:0]};

  assign aw_hs = aw_valid && aw_ready;
  assign w_hs  = w_valid && w_ready;
  assign w_ok  = !ErrEn || in_range(w_idx_q);
  assign ar_hs = ar_valid && ar_ready;
  assign r_hs  = r_valid && r_ready;

  // Write FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_state_q <= WIdle;
    else        w_state_q <= w_state_d;
  end

  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      WIdle:   if (aw_valid) w_state_d = WData;
      WData:   if (w_valid && (w_cnt_q == w_len_q)) w_state_d = WResp;
      WResp:   if (b_ready) w_state_d = WIdle;
      default: w_state_d = WIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_idx_q <= '0;
      w_len_q <= '0;
      w_cnt_q <= '0;
      w_err_q <= 1'b0;
      b_id_q  <= '0;
    end else if (aw_hs) begin
      w_idx_q <= aw_addr[AXI_ADDR_WIDTH-1:ByteShift];
      w_len_q <= aw_len;
      w_cnt_q <= '0;
      w_err_q <= 1'b0;
      b_id_q  <= aw_id;
    end else if (w_hs) begin
      w_idx_q <= w_idx_q + IdxW'(1);
      w_cnt_q <= w_cnt_q + 8'd1;
      if (!w_ok) w_err_q <= 1'b1;
    end
  end

  // Memory is intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_hs && w_ok) begin
      for (int b = 0; b < StrbW; b++) begin
        if (w_strb[b]) mem_q[mem_addr(w_idx_q)][b*8 +: 8] <= w_data[b*8 +: 8];
      end
    end
  end

  // Read FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state_q <= RIdle;
    else        r_state_q <= r_state_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      RIdle:   if (ar_valid) r_state_d = RData;
      RData:   if (r_ready && r_last_q) r_state_d = RIdle;
      default: r_state_d = RIdle;
    endcase
  end

  // Read port samples memory on the launch cycle, so a same-cycle write is not yet visible.
  assign rd_idx  = (r_state_q == RIdle) ? ar_addr[AXI_ADDR_WIDTH-1:ByteShift] : r_idx_q;
  assign rd_word = mem_q[mem_addr(rd_idx)];
  assign rd_ok   = !ErrEn || in_range(rd_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx_q  <= '0;
      r_len_q  <= '0;
      r_cnt_q  <= '0;
      r_id_q   <= '0;
      r_data_q <= '0;
      r_resp_q <= 2'b00;
      r_last_q <= 1'b0;
    end else if (ar_hs) begin
      r_idx_q  <= rd_idx + IdxW'(1);
      r_len_q  <= ar_len;
      r_cnt_q  <= '0;
      r_id_q   <= ar_id;
      r_data_q <= rd_ok ? rd_word : '0;
      r_resp_q <= rd_ok ? 2'b00 : 2'b10;
      r_last_q <= (ar_len == 8'd0);
    end else if (r_hs) begin
      if (r_last_q) begin
        r_last_q <= 1'b0;
      end else begin
        r_idx_q  <= r_idx_q + IdxW'(1);
        r_cnt_q  <= r_cnt_q + 8'd1;
        r_data_q <= rd_ok ? rd_word : '0;
        r_resp_q <= rd_ok ? 2'b00 : 2'b10;
        r_last_q <= ((r_cnt_q + 8'd1) == r_len_q);
      end
    end
  end

  // Outputs
  always_comb begin
    aw_ready = (w_state_q == WIdle);
    w_ready  = (w_state_q == WData);
    b_valid  = (w_state_q == WResp);
    b_id     = b_id_q;
    b_resp   = {w_err_q, 1'b0};
    ar_ready = (r_state_q == RIdle);
    r_valid  = (r_state_q == RData);
    r_id     = r_id_q;
    r_data   = r_data_q;
    r_resp   = r_resp_q;
    r_last   = r_last_q;
  end

endmodule

// File: tb/tb_axi_slv_mem.sv
// Randomized scoreboard bench for axi_slv_mem; a monitor pops expected B/R responses on handshakes.
// Expected values come from a word-array model honouring AXI_SLV_MEM_ERR_EN when defined.
module tb_axi_slv_mem;
  localparam int DEPTH = 256;

`ifdef AXI_SLV_MEM_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic        clk, rst_n;
  logic [3:0]  aw_id, b_id, ar_id, r_id;
  logic [31:0] aw_addr, ar_addr;
  logic [7:0]  aw_len, ar_len, w_strb;
  logic        aw_valid, aw_ready, w_last, w_valid, w_ready;
  logic [63:0] w_data, r_data;
  logic [1:0]  b_resp, r_resp;
  logic        b_valid, b_ready, ar_valid, ar_ready, r_last, r_valid, r_ready;

  axi_slv_mem dut (
    .clk(clk), .rst_n(rst_n),
    .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
    .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_valid(r_valid),
    .r_ready(r_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {logic [3:0] id; logic [1:0] resp;} b_exp_t;
  typedef struct {logic [3:0] id; logic [1:0] resp; logic last; logic [63:0] data;} r_exp_t;

  logic [63:0] model [DEPTH];
  b_exp_t      b_q[$];
  r_exp_t      r_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          hold_r = 0;
  int          hold_b = 0;

  function automatic bit oob(input int unsigned idx);
    return ErrEn && (idx >= DEPTH);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s_timeout: got no completion, required one within bound", name);
  endtask

  // Ready drivers: random backpressure, plus forced holds counted only while valid is up.
  initial begin
    r_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hold_r > 0) begin
        r_ready = 1'b0;
        if (r_valid) hold_r--;
      end else r_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    b_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hold_b > 0) begin
        b_ready = 1'b0;
        if (b_valid) hold_b--;
      end else b_ready = ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor
  initial begin
    logic [70:0] prev;
    bit          stall;
    b_exp_t      be;
    r_exp_t      re;
    stall = 1'b0;
    prev  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        if (b_valid) check("aw_ready_while_b", {127'd0, aw_ready}, 128'd0);
        if (b_valid && b_ready) begin
          if (b_q.size() == 0) check("b_unexpected", {127'd0, b_valid}, 128'd0);
          else begin
            be = b_q.pop_front();
            check("b_id_resp", {122'd0, b_id, b_resp}, {122'd0, be.id, be.resp});
          end
        end
        if (r_valid && stall) check("r_hold", {57'd0, r_id, r_resp, r_last, r_data}, {57'd0, prev});
        if (r_valid && r_ready) begin
          if (r_q.size() == 0) check("r_unexpected", {127'd0, r_valid}, 128'd0);
          else begin
            re = r_q.pop_front();
            check("r_beat", {57'd0, r_id, r_resp, r_last, r_data},
                  {57'd0, re.id, re.resp, re.last, re.data});
          end
        end
        stall = r_valid && !r_ready;
        prev  = {r_id, r_resp, r_last, r_data};
      end
    end
  end

  task automatic wait_hs(input string name, input int which, output bit ok);
    logic rdy;
    ok = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      rdy = (which == 0) ? aw_ready : (which == 1) ? w_ready : ar_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout(name);
  endtask

  // mode 0: fixed data and strobe; 1: random data, fixed strobe; 2: random data and strobe
  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                          input int mode, input logic [63:0] fdata, input logic [7:0] fstrb);
    bit          ok, err;
    int unsigned idx;
    logic [63:0] d;
    logic [7:0]  s;
    err = 1'b0;
    aw_id = id; aw_addr = addr; aw_len = len; aw_valid = 1'b1;
    wait_hs("aw", 0, ok);
    aw_valid = 1'b0;
    if (!ok) return;
    for (int k = 0; k <= int'(len); k++) begin
      repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      d = (mode == 0) ? fdata : {$urandom, $urandom};
      s = (mode == 2) ? 8'($urandom_range(0, 255)) : fstrb;
      w_data = d; w_strb = s; w_last = (k == int'(len)); w_valid = 1'b1;
      wait_hs("w", 1, ok);
      w_valid = 1'b0;
      if (!ok) return;
      idx = (addr >> 3) + k;
      if (oob(idx)) err = 1'b1;
      else for (int b = 0; b < 8; b++) if (s[b]) model[idx % DEPTH][b*8 +: 8] = d[b*8 +: 8];
    end
    b_q.push_back('{id: id, resp: err ? 2'b10 : 2'b00});
    ok = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (aw_ready) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("b");
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                         input int stall_after);
    bit          ok;
    int unsigned idx;
    for (int k = 0; k <= int'(len); k++) begin
      idx = (addr >> 3) + k;
      r_q.push_back('{id: id, resp: oob(idx) ? 2'b10 : 2'b00, last: (k == int'(len)),
                      data: oob(idx) ? 64'd0 : model[idx % DEPTH]});
    end
    ar_id = id; ar_addr = addr; ar_len = len; ar_valid = 1'b1;
    wait_hs("ar", 2, ok);
    ar_valid = 1'b0;
    if (!ok) begin r_q.delete(); return; end
    if (stall_after > 0) begin
      for (int n = 0; n < 1000 && r_q.size() > int'(len) + 1 - stall_after; n++) @(posedge clk);
      hold_r = 5;
    end
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      if (r_q.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) begin timeout("r"); r_q.delete(); end
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy"}, {124'd0, aw_ready, ar_ready, w_ready, b_valid}, {124'd0, 4'b1100});
    check({tag, "_r"}, {57'd0, r_valid, r_last, r_id, r_resp, r_data}, 128'd0);
    check({tag, "_b"}, {122'd0, b_id, b_resp}, 128'd0);
  endtask

  initial begin
    logic [31:0] a;
    bit          ok;
    rst_n = 1'b0;
    aw_id = '0; aw_addr = '0; aw_len = '0; aw_valid = 1'b0;
    w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0;
    ar_id = '0; ar_addr = '0; ar_len = '0; ar_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill the whole memory with one 256-beat burst, then read it back.
    do_write(32'h0, 8'd255, 4'd1, 1, 64'd0, 8'hFF);
    do_read(32'h0, 8'd255, 4'd2, 0);

    hold_b = 3;
    do_write(32'h40, 8'd3, 4'd5, 1, 64'd0, 8'hFF);
    do_read(32'h40, 8'd3, 4'd7, 2);

    do_write(32'h80, 8'd0, 4'd3, 0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    do_write(32'h80, 8'd0, 4'd3, 0, 64'd0, 8'h0F);
    do_read(32'h80, 8'd0, 4'd4, 0);

    do_read(32'd255 * 8, 8'd1, 4'd6, 0);
    do_write(32'd254 * 8, 8'd3, 4'd8, 2, 64'd0, 8'h00);
    do_read(32'd254 * 8, 8'd3, 4'd9, 0);

    for (int i = 0; i < 30; i++) begin
      a = 32'($urandom_range(0, 300)) * 8 + 32'($urandom_range(0, 7));
      do_write(a, 8'($urandom_range(0, 15)), 4'($urandom), 2, 64'd0, 8'h00);
      do_read(a, 8'($urandom_range(0, 15)), 4'($urandom), (i % 5 == 0) ? 1 : 0);
    end

    // Reset in the middle of beat 2 of an 8-beat write.
    aw_id = 4'd3; aw_addr = 32'h100; aw_len = 8'd7; aw_valid = 1'b1;
    wait_hs("aw_rst", 0, ok);
    aw_valid = 1'b0;
    w_data = {$urandom, $urandom}; w_strb = 8'hFF; w_last = 1'b0; w_valid = 1'b1;
    wait_hs("w_rst", 1, ok);
    if (ok) model[32] = w_data;
    w_data = {$urandom, $urandom};
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {125'd0, aw_ready, w_ready, b_valid}, {125'd0, 3'b100});
    @(posedge clk);
    #1;
    w_valid = 1'b0;
    check_reset_outputs("midburst_reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_write(32'h100, 8'd7, 4'd10, 1, 64'd0, 8'hFF);
    do_read(32'hF8, 8'd9, 4'd11, 0);

    repeat (5) @(posedge clk);
    #1;
    check("b_queue_drained", 128'(b_q.size()), 128'd0);
    check("r_queue_drained", 128'(r_q.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
